// File: rtl/array_2d_flatten_stream_if.sv
// Handshake bundle for the matrix flattener: matrix-in side plus beat-out side.
// The slave modport is the flattener; the master modport is the surrounding fabric.
interface array_2d_flatten_stream_if #(
  parameter int BIT_WIDTH      = 4,
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int ELEMS_PER_BEAT = 8
);
  logic [BIT_WIDTH-1:0]                in_data [ROWS][COLS];
  logic                                in_order;
  logic                                in_valid;
  logic                                in_ready;
  logic [ELEMS_PER_BEAT*BIT_WIDTH-1:0] out_data;
  logic [ELEMS_PER_BEAT-1:0]           out_keep;
  logic                                out_last;
  logic                                out_valid;
  logic                                out_ready;
  logic                                busy;

  modport slave (
    input  in_data, in_order, in_valid, out_ready,
    output in_ready, out_data, out_keep, out_last, out_valid, busy
  );

  modport master (
    output in_data, in_order, in_valid, out_ready,
    input  in_ready, out_data, out_keep, out_last, out_valid, busy
  );
endinterface

// File: rtl/array_2d_flatten_stream.sv
// Captures a ROWS x COLS matrix and streams it flattened, ELEMS_PER_BEAT lanes per beat,
// in column-major (k = j*ROWS+i) or row-major (k = i*COLS+j) order chosen per matrix.
//
// state | meaning
// IDLE  | no matrix held, out_valid low, ready for a new matrix
// SEND  | matrix held, beat_q selects the beat being offered
module array_2d_flatten_stream #(
  parameter int BIT_WIDTH      = 4,
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int ELEMS_PER_BEAT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  array_2d_flatten_stream_if.slave    bus
);

  localparam int N     = ROWS * COLS;
  localparam int BEATS = (N + ELEMS_PER_BEAT - 1) / ELEMS_PER_BEAT;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BW    = ELEMS_PER_BEAT * BIT_WIDTH;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        beat_q, beat_d;
  logic [BIT_WIDTH-1:0] buf_q [ROWS][COLS];
  logic                 order_q;

  logic                 accept;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_last;
  logic [BW-1:0]        out_data;
  logic [ELEMS_PER_BEAT-1:0] out_keep;

  logic [BIT_WIDTH-1:0] flat_col [N];
  logic [BIT_WIDTH-1:0] flat_row [N];
  logic [BW-1:0]        beat_col [BEATS];
  logic [BW-1:0]        beat_row [BEATS];
  logic [BW-1:0]        sel_data;
  logic [ELEMS_PER_BEAT-1:0] sel_keep;

  assign accept = bus.in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          beat_d  = '0;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (out_last) begin
            beat_d  = '0;
            state_d = accept ? SEND : IDLE;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Outputs depend only on registered state, so no in_data path reaches them
  always_comb begin
    out_valid = (state_q == SEND);
    out_last  = out_valid && (beat_q == LAST_BEAT);
    out_data  = out_valid ? sel_data : '0;
    out_keep  = out_valid ? sel_keep : '0;
    in_ready  = !out_valid || (bus.out_ready && out_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_q <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          buf_q[r][c] <= '0;
    end else if (accept) begin
      order_q <= bus.in_order;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          buf_q[r][c] <= bus.in_data[r][c];
    end
  end

  // Both orderings are pure wiring of the buffer; padding lanes are tied to zero
  for (genvar k = 0; k < N; k++) begin : g_flat
    assign flat_col[k] = buf_q[k % ROWS][k / ROWS];
    assign flat_row[k] = buf_q[k / COLS][k % COLS];
  end

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    for (genvar l = 0; l < ELEMS_PER_BEAT; l++) begin : g_lane
      if (b * ELEMS_PER_BEAT + l < N) begin : g_real
        assign beat_col[b][l*BIT_WIDTH +: BIT_WIDTH] = flat_col[b*ELEMS_PER_BEAT + l];
        assign beat_row[b][l*BIT_WIDTH +: BIT_WIDTH] = flat_row[b*ELEMS_PER_BEAT + l];
      end else begin : g_pad
        assign beat_col[b][l*BIT_WIDTH +: BIT_WIDTH] = '0;
        assign beat_row[b][l*BIT_WIDTH +: BIT_WIDTH] = '0;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == CW'(b))
        sel_data = order_q ? beat_row[b] : beat_col[b];
    end
    sel_keep = '0;
    for (int l = 0; l < ELEMS_PER_BEAT; l++)
      sel_keep[l] = ((int'(beat_q) * ELEMS_PER_BEAT + l) < N);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_data  = out_data;
  assign bus.out_keep  = out_keep;
  assign bus.busy      = out_valid;

endmodule

// File: tb/tb_array_2d_flatten_stream.sv
// Directed bench: a 2x3/4-lane instance for ordering, backpressure, back-to-back and
// reset cases, plus a default 8x8/8-lane instance for the full column-major sweep.
module tb_array_2d_flatten_stream;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  array_2d_flatten_stream_if #(.BIT_WIDTH(4), .ROWS(2), .COLS(3), .ELEMS_PER_BEAT(4)) ifa ();
  array_2d_flatten_stream_if ifb ();

  array_2d_flatten_stream #(.BIT_WIDTH(4), .ROWS(2), .COLS(3), .ELEMS_PER_BEAT(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (ifa.slave)
  );

  array_2d_flatten_stream dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (ifb.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Element (i,j) of the small matrix is nibble (i*3+j) of m
  task automatic set_a(input logic [23:0] m, input logic order);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++)
        ifa.in_data[i][j] = m[(i*3+j)*4 +: 4];
    ifa.in_order = order;
  endtask

  task automatic check_a_beat(input string tag, input logic [15:0] data,
                              input logic [3:0] keep, input logic last);
    check({tag, "_valid"}, 64'(ifa.out_valid), 64'd1);
    check({tag, "_data"},  64'(ifa.out_data),  64'(data));
    check({tag, "_keep"},  64'(ifa.out_keep),  64'(keep));
    check({tag, "_last"},  64'(ifa.out_last),  64'(last));
  endtask

  task automatic check_a_idle(input string tag);
    check({tag, "_valid"}, 64'(ifa.out_valid), 64'd0);
    check({tag, "_busy"},  64'(ifa.busy),      64'd0);
    check({tag, "_data"},  64'(ifa.out_data),  64'd0);
    check({tag, "_keep"},  64'(ifa.out_keep),  64'd0);
    check({tag, "_last"},  64'(ifa.out_last),  64'd0);
  endtask

  logic [31:0] exp_b;

  initial begin
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    set_a(24'h0, 1'b0);
    ifb.in_valid = 1'b0;
    ifb.out_ready = 1'b1;
    ifb.in_order = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        ifb.in_data[i][j] = 4'((i*8 + j) % 16);

    // Reset state
    @(negedge clk);
    check_a_idle("rst");
    check("rst_in_ready", 64'(ifa.in_ready), 64'd1);
    ifa.in_valid = 1'b1;
    set_a(24'h654321, 1'b0);
    @(negedge clk);
    check("rst_no_capture", 64'(ifa.out_valid), 64'd0);
    ifa.in_valid = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Column-major
    @(negedge clk);
    set_a(24'h654321, 1'b0);
    ifa.in_valid = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    check_a_beat("cm_b0", 16'h5241, 4'b1111, 1'b0);
    @(negedge clk);
    check_a_beat("cm_b1", 16'h0063, 4'b0011, 1'b1);
    @(negedge clk);
    check_a_idle("cm_end");

    // Row-major
    set_a(24'h654321, 1'b1);
    ifa.in_valid = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    check_a_beat("rm_b0", 16'h4321, 4'b1111, 1'b0);
    @(negedge clk);
    check_a_beat("rm_b1", 16'h0065, 4'b0011, 1'b1);
    @(negedge clk);
    check_a_idle("rm_end");

    // Backpressure on beat0; all-F matrix offered meanwhile must be ignored
    set_a(24'h654321, 1'b0);
    ifa.in_valid = 1'b1;
    ifa.out_ready = 1'b0;
    @(negedge clk);
    set_a(24'hFFFFFF, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check_a_beat($sformatf("bp%0d", c), 16'h5241, 4'b1111, 1'b0);
      check($sformatf("bp%0d_in_ready", c), 64'(ifa.in_ready), 64'd0);
      @(negedge clk);
    end
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    check("bp_rel_in_ready", 64'(ifa.in_ready), 64'd0);
    @(negedge clk);
    check_a_beat("bp_b1", 16'h0063, 4'b0011, 1'b1);
    @(negedge clk);
    check_a_idle("bp_end");

    // Back-to-back matrices
    set_a(24'h654321, 1'b0);
    ifa.in_valid = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    check_a_beat("bb_m0_b0", 16'h5241, 4'b1111, 1'b0);
    @(negedge clk);
    check_a_beat("bb_m0_b1", 16'h0063, 4'b0011, 1'b1);
    set_a(24'hCBA987, 1'b1);
    ifa.in_valid = 1'b1;
    #1;
    check("bb_in_ready", 64'(ifa.in_ready), 64'd1);
    @(negedge clk);
    ifa.in_valid = 1'b0;
    check_a_beat("bb_m1_b0", 16'hA987, 4'b1111, 1'b0);
    @(negedge clk);
    check_a_beat("bb_m1_b1", 16'h00CB, 4'b0011, 1'b1);
    @(negedge clk);
    check_a_idle("bb_end");

    // Reset mid-transfer, just after beat0 is taken
    set_a(24'h654321, 1'b0);
    ifa.in_valid = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    check_a_beat("mr_b0", 16'h5241, 4'b1111, 1'b0);
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    #1;
    check_a_idle("mr_async");
    @(negedge clk);
    rst_a = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("mr_post%0d_in_ready", c), 64'(ifa.in_ready), 64'd1);
      check($sformatf("mr_post%0d_valid", c), 64'(ifa.out_valid), 64'd0);
      @(negedge clk);
    end

    // Default 8x8 instance: column-major, beat b lane L = (L*8+b) mod 16
    check("def_rst_valid", 64'(ifb.out_valid), 64'd0);
    ifb.in_valid = 1'b1;
    @(negedge clk);
    ifb.in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      exp_b = '0;
      for (int l = 0; l < 8; l++)
        exp_b[l*4 +: 4] = 4'((l*8 + b) % 16);
      check($sformatf("def_b%0d_valid", b), 64'(ifb.out_valid), 64'd1);
      check($sformatf("def_b%0d_data", b), 64'(ifb.out_data), 64'(exp_b));
      check($sformatf("def_b%0d_keep", b), 64'(ifb.out_keep), 64'hFF);
      check($sformatf("def_b%0d_last", b), 64'(ifb.out_last), (b == 7) ? 64'd1 : 64'd0);
      @(negedge clk);
    end
    check("def_end_valid", 64'(ifb.out_valid), 64'd0);
    check("def_end_busy", 64'(ifb.busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
